// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit counter width for a given operand width: $clog2(width), never below 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell used as the serial adder datapath; purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: walks one full_adder across WIDTH cycles, LSB first,
// and publishes {cout_out, sum_out} with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH:0]   w_sum_cat;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  // Concatenate-then-slice keeps the right shift legal for WIDTH=1.
  assign w_sum_cat = {w_fa_sum, r_sum_sh};

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= a_in;
      r_b_sh   <= b_in;
      r_sum_sh <= '0;
      r_carry  <= cin_in;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_sum_sh <= w_sum_cat[WIDTH:1];
      r_carry  <= w_fa_cout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        sum_out  <= w_sum_cat[WIDTH:1];
        cout_out <= w_fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random operands
// compared against a plain-arithmetic reference of a + b + cin.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic c);
    return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_sum"},  64'(sum_out), 64'd0);
    chk({tag, "_cout"}, 64'(cout_out), 64'd0);
  endtask

  // Launch one operation with a single-cycle start and check timing and result.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic c);
    logic [WIDTH:0] exp;
    int busy_cnt;
    int guard;
    exp = ref_add(a, b, c);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin_in = c;
    @(negedge clk);
    start = 1'b0;
    a_in = WIDTH'($urandom); b_in = WIDTH'($urandom); cin_in = 1'($urandom);
    busy_cnt = 0;
    guard = 0;
    while (!done && guard < WIDTH + 5) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
    chk({tag, "_sum"}, 64'(sum_out), 64'(exp[WIDTH-1:0]));
    chk({tag, "_cout"}, 64'(cout_out), 64'(exp[WIDTH]));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_sum_held"}, 64'(sum_out), 64'(exp[WIDTH-1:0]));
  endtask

  initial begin
    int dones;
    int t_first;
    int t_second;
    int guard;
    logic [WIDTH-1:0] cap_sum;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    #1 chk_idle_outputs("reset_t0");
    @(negedge clk); chk_idle_outputs("reset_c1");
    @(negedge clk); chk_idle_outputs("reset_c2");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("idle_no_start");

    do_op("basic", 8'h5A, 8'h33, 1'b0);
    chk("basic_const", 64'(sum_out), 64'h8D);
    do_op("ripple1", 8'hFF, 8'h01, 1'b0);
    chk("ripple1_const", 64'({cout_out, sum_out}), 64'h100);
    do_op("ripple2", 8'hFF, 8'hFF, 1'b1);
    chk("ripple2_const", 64'({cout_out, sum_out}), 64'h1FF);

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; a_in = 8'h5A; b_in = 8'h33; cin_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    dones = 0; cap_sum = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin start = 1'b1; a_in = 8'h10; b_in = 8'h10; end
      if (i == 3) start = 1'b0;
      if (done) begin dones++; cap_sum = sum_out; end
      @(negedge clk);
    end
    chk("busy_start_dones", 64'(dones), 64'd1);
    chk("busy_start_sum", 64'(cap_sum), 64'h8D);

    // Back-to-back with start held high.
    start = 1'b1; a_in = 8'h01; b_in = 8'h02; cin_in = 1'b0;
    @(negedge clk);
    a_in = 8'h80; b_in = 8'h80;
    guard = 0;
    while (!done && guard < 3 * WIDTH) begin @(negedge clk); guard++; end
    t_first = cyc;
    chk("b2b_first_done", 64'(done), 64'd1);
    chk("b2b_first_res", 64'({cout_out, sum_out}), 64'h003);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_bubble", 64'(busy), 64'd1);
    guard = 0;
    while (!done && guard < 3 * WIDTH) begin @(negedge clk); guard++; end
    t_second = cyc;
    chk("b2b_second_done", 64'(done), 64'd1);
    chk("b2b_spacing", 64'(t_second - t_first), 64'(WIDTH + 1));
    chk("b2b_second_res", 64'({cout_out, sum_out}), 64'h100);
    @(negedge clk);
    chk("b2b_idle_after", 64'(done), 64'd0);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; a_in = 8'h5A; b_in = 8'h33; cin_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_running", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("midrst_async");
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    do_op("after_rst", 8'h7F, 8'h01, 1'b0);
    chk("after_rst_const", 64'({cout_out, sum_out}), 64'h080);

    for (int n = 0; n < 24; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      do_op($sformatf("rand%0d", n), ra, rb, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
